rom_loader: RTL and testbench
=============================

# rom_loader

Upstream feeder for the ROM/RAM image store. Receives a byte stream from the SiDi board firmware over its SPI link and writes it byte-by-byte into a write port on the ROM image memory. Auto-increments the address. Holds the machine in download mode (`busy`) from start to end of a transfer, so the Z80 stays reset while the ROM image is replaced.

## Interface
Parameters:
- `AW`, 14, image address width; image size 2**AW bytes

Ports:
- `clock`  in  1  system clock; all logic on posedge
- `reset`  in  1  asynchronous, active-low reset
- `spiCk`  in  1  firmware SPI clock; asynchronous to `clock`
- `spiSs`  in  1  firmware SPI select, active-low; frames the bytes
- `spiDi`  in  1  firmware SPI data, MSB first, sampled on `spiCk` rising edge
- `busy`  out  1  download in progress; drives CPU reset upstream
- `index`  out  8  image index from the last START command
- `wr`  out  1  one-clock write strobe to the image memory
- `a`  out  AW  write address
- `d`  out  8  write data
- `ovf`  out  1  sticky flag: image bytes arrived past address 2**AW-1
- `sum`  out  8  running XOR of all data bytes since START

## Operation
- `spiCk`, `spiSs` and `spiDi` each pass through a 2-FF synchronizer.
- A rising edge of synchronized `spiCk` while synchronized `spiSs`=0 shifts `spiDi` into an 8-bit register, MSB first.
- A 3-bit counter marks the byte complete on the 8th bit.
- Synchronized `spiSs`=1 clears the bit counter and forces the frame state to CMD. A partial byte is discarded.
- Frame FSM:
  - CMD: first byte of a frame.
    - 0x53 START → INDEX.
    - 0x55 DATA → DATA.
    - 0x54 END → clear `busy`, then IGNORE.
    - Any other byte → IGNORE.
  - INDEX: next byte is latched into `index`. Also set `busy`=1, `a`=0, `ovf`=0, `sum`=0, then go to IGNORE.
  - DATA: each byte is written to the image.
    - If `busy`=0, the byte is dropped.
    - If `ovf`=1, the byte is dropped.
    - Otherwise present `d`=byte and `a`, and pulse `wr`.
    - After the write, `a` increments. `sum` ^= byte.
    - A write at `a`=2**AW-1 sets `ovf`, and `a` wraps to 0. Later bytes are dropped, but `sum` still accumulates.
    - Stay in DATA until `spiSs` goes high.
  - IGNORE: discard bytes until `spiSs` goes high.
- `busy` is only cleared by END or reset. An aborted frame (`spiSs` high mid-byte) leaves `busy` and `a` unchanged.
- Once set, `ovf` stays set until the next START.

## Timing
- Reset values: `busy`=0, `index`=0, `wr`=0, `a`=0, `d`=0, `ovf`=0, `sum`=0, FSM=CMD, bit counter=0.
- Reset is asynchronous and takes effect mid-transfer with no pending write.
- Input latency: 2 sync clocks plus 1 edge-detect clock. The 8th `spiCk` pin rise produces `wr` high on the 4th `clock` rising edge after it.
- `wr` is high for exactly one cycle.
- `a` and `d` are stable while `wr`=1. `a` updates on the cycle after `wr`.
- `spiCk` high and low phases must each be ≥ 3 `clock` periods. `spiSs` must be high ≥ 3 `clock` periods between frames.
- If `spiSs` rises in the same cycle a byte completes, the byte is processed first and the frame then closes.
- The image memory must accept a write on every `wr` pulse; there is no backpressure.

## Structure
- Shared package `zx48_pkg` holds the command constants CMD_START=8'h53, CMD_END=8'h54, CMD_DATA=8'h55.
- The frame-state enum (CMD, INDEX, DATA, IGNORE) also lives in `zx48_pkg`.
- One sub-module, `spi_rx`:
  - Contains the synchronizers, edge detector, bit counter and shift register.
  - Outputs `byteStb`, `byteQ[7:0]` and `ssOff`.
- The FSM, address counter, `ovf` and `sum` logic stay in `rom_loader`.

## Test plan
- Frame {0x53,0x02}, then frame {0x55,0xF3,0xAF,0x11}, then frame {0x54}:
  - `index`=2, `busy`=1 after the first frame.
  - Three `wr` pulses at `a`=0,1,2 with `d`=F3,AF,11.
  - `sum`=0x4D.
  - `busy`=0 after END.
- AW=4, START, then 17 DATA bytes 0x00..0x10:
  - 16 writes at `a`=0..15; `ovf`=1 after the 16th.
  - 17th byte is not written; `a`=0.
  - `sum`=0x10 (XOR of 0x00..0x10).
- DATA frame without a prior START: zero `wr` pulses; `busy`, `a` and `sum` unchanged.
- `spiSs` deasserted after 5 bits of a DATA byte:
  - No `wr` pulse.
  - Next frame {0x55,0x3C} writes 0x3C at the unchanged `a`.
- `reset` asserted low after 2 data bytes: all outputs return to their reset values immediately; no further `wr` pulse.
- Unknown command frame {0x99,0x12,0x34}: no writes, `index` unchanged, FSM back in CMD after `spiSs` rises.

Source files
------------

// File: rtl/zx48_pkg.sv
// Shared constants and types for the ZX48 image loader.
// Holds the firmware command bytes and the frame-state encoding.
package zx48_pkg;

  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_END   = 8'h54;
  localparam logic [7:0] CMD_DATA  = 8'h55;

  typedef enum logic [1:0] {
    FS_CMD,
    FS_INDEX,
    FS_DATA,
    FS_IGNORE
  } frame_t;

endpackage

// File: rtl/rom_loader_spi_rx.sv
// SPI byte receiver for the firmware link, oversampled by the system clock.
// Syncs the pins, detects spiCk rises and assembles bytes MSB first.
module spi_rx
  import zx48_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       spiCk,
  input  logic       spiSs,
  input  logic       spiDi,
  output logic       byteStb,
  output logic [7:0] byteQ,
  output logic       ssOff
);

  logic [1:0] ckS;
  logic [1:0] ssS;
  logic [1:0] diS;
  logic       ckP;
  logic [2:0] cnt;
  logic [7:0] sh;
  logic       rise;

  assign rise  = ckS[1] & ~ckP;
  assign ssOff = ssS[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ckS     <= 2'b00;
      ssS     <= 2'b11;
      diS     <= 2'b00;
      ckP     <= 1'b0;
      cnt     <= 3'd0;
      sh      <= 8'h00;
      byteStb <= 1'b0;
      byteQ   <= 8'h00;
    end else begin
      ckS     <= {ckS[0], spiCk};
      ssS     <= {ssS[0], spiSs};
      diS     <= {diS[0], spiDi};
      ckP     <= ckS[1];
      byteStb <= 1'b0;
      if (ssS[1]) begin
        cnt <= 3'd0;
      end else if (rise) begin
        sh  <= {sh[6:0], diS[1]};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          byteStb <= 1'b1;
          byteQ   <= {sh[6:0], diS[1]};
        end
      end
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Firmware-driven ROM image loader: frames SPI bytes into image writes.
// Holds busy from START to END so the CPU stays in reset meanwhile.
module rom_loader
  import zx48_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          spiCk,
  input  logic          spiSs,
  input  logic          spiDi,
  output logic          busy,
  output logic [7:0]    index,
  output logic          wr,
  output logic [AW-1:0] a,
  output logic [7:0]    d,
  output logic          ovf,
  output logic [7:0]    sum
);

  logic       byteStb;
  logic [7:0] byteQ;
  logic       ssOff;
  frame_t     st;

  spi_rx u_rx (
    .clock   (clock),
    .reset   (reset),
    .spiCk   (spiCk),
    .spiSs   (spiSs),
    .spiDi   (spiDi),
    .byteStb (byteStb),
    .byteQ   (byteQ),
    .ssOff   (ssOff)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st    <= FS_CMD;
      busy  <= 1'b0;
      index <= 8'h00;
      wr    <= 1'b0;
      a     <= '0;
      d     <= 8'h00;
      ovf   <= 1'b0;
      sum   <= 8'h00;
    end else begin
      wr <= 1'b0;
      // address advances only after the strobe so a/d hold during wr
      if (wr) begin
        a <= a + 1'b1;
        if (&a)
          ovf <= 1'b1;
      end
      if (byteStb) begin
        case (st)
          FS_CMD: begin
            unique case (1'b1)
              byteQ == CMD_START: st <= FS_INDEX;
              byteQ == CMD_DATA:  st <= FS_DATA;
              byteQ == CMD_END: begin
                busy <= 1'b0;
                st   <= FS_IGNORE;
              end
              default: st <= FS_IGNORE;
            endcase
          end
          FS_INDEX: begin
            index <= byteQ;
            busy  <= 1'b1;
            a     <= '0;
            ovf   <= 1'b0;
            sum   <= 8'h00;
            st    <= FS_IGNORE;
          end
          FS_DATA: begin
            if (busy) begin
              sum <= sum ^ byteQ;
              if (!ovf) begin
                d  <= byteQ;
                wr <= 1'b1;
              end
            end
          end
          default: st <= FS_IGNORE;
        endcase
      end
      // a closing select wins over the state chosen by the last byte
      if (ssOff)
        st <= FS_CMD;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with a 4-bit image address.
// Drives SPI frames and checks strobes, addresses, data and flags.
module tb_rom_loader;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          spiCk = 1'b0;
  logic          spiSs = 1'b1;
  logic          spiDi = 1'b0;
  logic          busy;
  logic [7:0]    index;
  logic          wr;
  logic [AW-1:0] a;
  logic [7:0]    d;
  logic          ovf;
  logic [7:0]    sum;

  int total = 0;
  int bad   = 0;
  int wrCnt = 0;
  int wa[$];
  int wd[$];
  time t8 = 0;
  time tw = 0;
  logic prevWr = 1'b0;

  rom_loader #(.AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .spiCk (spiCk),
    .spiSs (spiSs),
    .spiDi (spiDi),
    .busy  (busy),
    .index (index),
    .wr    (wr),
    .a     (a),
    .d     (d),
    .ovf   (ovf),
    .sum   (sum)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (wr) begin
      chk("wr1", int'(prevWr), 0);
      wrCnt++;
      wa.push_back(int'(a));
      wd.push_back(int'(d));
      tw = $time;
    end
    prevWr = wr;
  end

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spiDi = b[i];
      #40 spiCk = 1'b1;
      t8 = $time;
      #40 spiCk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] bs[$]);
    spiSs = 1'b0;
    #40;
    foreach (bs[i]) sendBits(bs[i], 8);
    #40 spiSs = 1'b1;
    #100;
  endtask

  task automatic chkWr(input string tag, input int ea, input int ed);
    int ga;
    int gd;
    ga = -1;
    gd = -1;
    if (wa.size() > 0) begin
      ga = wa.pop_front();
      gd = wd.pop_front();
    end
    chk({tag, "_a"}, ga, ea);
    chk({tag, "_d"}, gd, ed);
  endtask

  initial begin
    logic [7:0] q[$];
    int n0;
    #30;
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr", int'(wr), 0);
    reset = 1'b1;
    #40;
    chk("idle_busy", int'(busy), 0);
    chk("idle_index", int'(index), 0);
    chk("idle_a", int'(a), 0);
    chk("idle_d", int'(d), 0);
    chk("idle_ovf", int'(ovf), 0);
    chk("idle_sum", int'(sum), 0);

    q = '{8'h55, 8'hAA, 8'hBB};
    frame(q);
    chk("nostart_wr", wrCnt, 0);
    chk("nostart_busy", int'(busy), 0);
    chk("nostart_a", int'(a), 0);
    chk("nostart_sum", int'(sum), 0);

    q = '{8'h99, 8'h12, 8'h34};
    frame(q);
    chk("unk_wr", wrCnt, 0);
    chk("unk_index", int'(index), 0);

    q = '{8'h53, 8'h02};
    frame(q);
    chk("start_index", int'(index), 2);
    chk("start_busy", int'(busy), 1);

    q = '{8'h55, 8'hF3, 8'hAF, 8'h11};
    frame(q);
    chk("data_cnt", wrCnt, 3);
    chkWr("w0", 0, 'hF3);
    chkWr("w1", 1, 'hAF);
    chkWr("w2", 2, 'h11);
    chk("data_sum", int'(sum), 'h4D);
    chk("data_a", int'(a), 3);
    chk("latency", int'(tw - t8), 40);

    spiSs = 1'b0;
    #40;
    sendBits(8'h55, 8);
    sendBits(8'hFF, 5);
    #40 spiSs = 1'b1;
    #100;
    chk("abort_wr", wrCnt, 3);
    chk("abort_a", int'(a), 3);
    chk("abort_busy", int'(busy), 1);
    q = '{8'h55, 8'h3C};
    frame(q);
    chkWr("w3", 3, 'h3C);
    chk("abort_sum", int'(sum), 'h71);

    q = '{8'h54};
    frame(q);
    chk("end_busy", int'(busy), 0);
    chk("end_index", int'(index), 2);

    q = '{8'h53, 8'h07};
    frame(q);
    chk("st2_a", int'(a), 0);
    chk("st2_sum", int'(sum), 0);
    q = '{8'h55};
    for (int i = 0; i <= 16; i++) q.push_back(8'(i));
    n0 = wrCnt;
    frame(q);
    chk("ovf_cnt", wrCnt - n0, 16);
    for (int i = 0; i < 16; i++) chkWr("ovw", i, i);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_a", int'(a), 0);
    chk("ovf_sum", int'(sum), 'h10);
    chk("ovf_index", int'(index), 7);

    q = '{8'h53, 8'h01};
    frame(q);
    spiSs = 1'b0;
    #40;
    sendBits(8'h55, 8);
    sendBits(8'hAA, 8);
    sendBits(8'hBB, 8);
    #80;
    n0 = wrCnt;
    chk("pre_a", int'(a), 2);
    sendBits(8'hCC, 4);
    reset = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_index", int'(index), 0);
    chk("ar_a", int'(a), 0);
    chk("ar_d", int'(d), 0);
    chk("ar_sum", int'(sum), 0);
    chk("ar_ovf", int'(ovf), 0);
    chk("ar_wr", int'(wr), 0);
    #39;
    sendBits(8'hCC, 4);
    #40 spiSs = 1'b1;
    #100;
    reset = 1'b1;
    #100;
    chk("ar_nowr", wrCnt - n0, 0);
    chk("ar_post_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
